// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - opcode constants, field positions and default widths for the fetch unit
package fetch_pkg;

  localparam int RAM_WIDTH_DEF = 22;
  localparam int ADDR_SIZE_DEF = 11;
  localparam int RAS_DEPTH_DEF = 4;

  localparam int OP_MSB  = 21;
  localparam int SUB_LSB = 14;
  localparam int TGT_MSB = 17;
  localparam int TGT_LSB = 8;

  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_BSR  = 4'b0111;
  localparam logic [7:0] SUB_RTS = 8'b00000110;

  typedef enum logic [1:0] {
    KIND_OTHER,
    KIND_JMP,
    KIND_BSR,
    KIND_RTS
  } word_kind_e;

  // hdr is the top byte of the instruction word, w[21:14]
  function automatic word_kind_e classify(input logic [7:0] hdr);
    if (hdr[7:4] == OP_JMP) return KIND_JMP;
    if (hdr[7:4] == OP_BSR) return KIND_BSR;
    if (hdr == SUB_RTS) return KIND_RTS;
    return KIND_OTHER;
  endfunction

endpackage

// File: rtl/fetch_return_stack.sv
// rtl/fetch_return_stack.sv - return-address stack; FETCH_STACK_CHECK_EN selects guarded overflow/underflow
module return_stack
  import fetch_pkg::*;
#(
  parameter int DEPTH        = RAS_DEPTH_DEF,
  parameter int AW           = ADDR_SIZE_DEF,
  parameter int RESET_VECTOR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] pop_data_o,
  output logic          err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d, top_idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, empty, do_push, do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign top_idx = sp_q - PW'(1);

`ifdef FETCH_STACK_CHECK_EN
  logic err_q, err_d;

  assign do_push    = push_i && !full;
  assign do_pop     = pop_i && !empty;
  assign pop_data_o = empty ? AW'(RESET_VECTOR) : mem_q[top_idx];
  assign err_d      = err_q | (push_i && full) | (pop_i && empty);
  assign err_o      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  // Circular buffer: overflow overwrites the oldest entry, underflow reads whatever is there
  assign do_push    = push_i;
  assign do_pop     = pop_i;
  assign pop_data_o = mem_q[top_idx];
  assign err_o      = 1'b0;
`endif

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      sp_d = sp_q + PW'(1);
      if (!full) cnt_d = cnt_q + (PW+1)'(1);
    end else if (do_pop) begin
      sp_d = top_idx;
      if (!empty) cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[sp_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and program-RAM read master; resolves JMP/BSR/RTS, forwards the rest
// Return-stack checking is selected by FETCH_STACK_CHECK_EN inside return_stack.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int RAM_WIDTH    = RAM_WIDTH_DEF,
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int RAS_DEPTH    = RAS_DEPTH_DEF,
  parameter int RESET_VECTOR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_rd_enb,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0] mem_data,
  output logic [RAM_WIDTH-1:0] instr_out,
  output logic [ADDR_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic                 stack_err
);

  localparam logic [ADDR_SIZE-1:0] RV = ADDR_SIZE'(RESET_VECTOR);

  logic [ADDR_SIZE-1:0] pc_q, pc_d, tag_q, tag_d;
  logic                 inflight_q, inflight_d, squash_q, squash_d;
  logic                 out_valid_q, out_valid_d;
  logic [RAM_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_SIZE-1:0] out_pc_q, out_pc_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [RAM_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_SIZE-1:0] skid_pc_q, skid_pc_d;

  logic                 stalled, issue, ret, redirect, deliver, push, pop;
  word_kind_e           kind;
  logic [ADDR_SIZE-1:0] tgt_abs, tgt_rel, ret_addr, pop_addr;

  assign stalled  = out_valid_q && !instr_ready;
  assign issue    = !stalled && !skid_valid_q;
  assign ret      = inflight_q && !squash_q;
  assign kind     = classify(mem_data[OP_MSB:SUB_LSB]);
  assign tgt_abs  = ADDR_SIZE'(mem_data[TGT_MSB:TGT_LSB]);
  assign tgt_rel  = tag_q + tgt_abs;
  assign ret_addr = tag_q + ADDR_SIZE'(1);

  always_comb begin
    pc_d         = issue ? pc_q + ADDR_SIZE'(1) : pc_q;
    tag_d        = issue ? pc_q : tag_q;
    inflight_d   = issue;
    redirect     = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (ret) begin
      case (kind)
        KIND_JMP: begin
          pc_d     = tgt_abs;
          redirect = 1'b1;
        end
        KIND_BSR: begin
          push     = 1'b1;
          pc_d     = tgt_rel;
          redirect = 1'b1;
        end
        KIND_RTS: begin
          pop      = 1'b1;
          pc_d     = pop_addr;
          redirect = 1'b1;
        end
        default: ;
      endcase
    end

    // Only a word actually issued alongside the redirect is on the wrong path
    squash_d = redirect && issue;
    deliver  = ret && (kind == KIND_OTHER);

    if (!stalled) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = deliver;
        if (deliver) begin
          out_instr_d = mem_data;
          out_pc_d    = tag_q;
        end
      end
    end else if (deliver) begin
      skid_valid_d = 1'b1;
      skid_instr_d = mem_data;
      skid_pc_d    = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RV;
      tag_q        <= '0;
      inflight_q   <= 1'b0;
      squash_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      squash_q     <= squash_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  return_stack #(
    .DEPTH       (RAS_DEPTH),
    .AW          (ADDR_SIZE),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(ret_addr),
    .pop_i      (pop),
    .pop_data_o (pop_addr),
    .err_o      (stack_err)
  );

  // Strobe held low while reset is asserted so the RAM sees no read during reset
  assign mem_rd_enb  = issue && rst_n;
  assign mem_addr    = pc_q;
  assign instr_out   = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit; stack-error expectations follow FETCH_STACK_CHECK_EN
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_enb;
  logic [10:0] mem_addr;
  logic [21:0] mem_data = '0;
  logic [21:0] instr_out;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        stack_err;

`ifdef FETCH_STACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  localparam logic [21:0] RTS_W = 22'h018000;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rd_enb (mem_rd_enb),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  logic [21:0] ram [0:2047];
  always @(posedge clk) if (mem_rd_enb) mem_data <= ram[mem_addr];

  int total = 0;
  int bad = 0;
  int ncol;
  logic [10:0] got_pc  [64];
  logic [21:0] got_ins [64];
  int          got_cyc [64];
  int exp_a [19] = '{0, 1, 2, 6, 7, 12, 13, 200, 201, 202, 203, 204, 205, 206, 15, 16, 17, 18, 9};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] enc_jmp(input logic [9:0] t);
    return {4'b1000, t, 8'h00};
  endfunction

  function automatic logic [21:0] enc_bsr(input logic [9:0] off);
    return {4'b0111, off, 8'h00};
  endfunction

  task automatic fill();
    for (int i = 0; i < 2048; i++) ram[i] = 22'h008000 | 22'(i & 255);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic collect(input int n, input int budget);
    ncol = 0;
    for (int c = 0; c < budget && ncol < n; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        got_pc[ncol]  = instr_pc;
        got_ins[ncol] = instr_out;
        got_cyc[ncol] = c;
        ncol++;
      end
    end
    check_eq("collect_count", ncol, n);
  endtask

  task automatic load_branch_prog();
    fill();
    ram[3]   = enc_jmp(10'd6);
    ram[8]   = enc_bsr(10'd4);
    ram[14]  = enc_bsr(10'd186);
    ram[207] = RTS_W;
    ram[19]  = RTS_W;
  endtask

  logic [21:0] held;
  logic        found;

  initial begin
    // reset values
    fill();
    @(posedge clk);
    #1;
    check_eq("rst_rd_enb", mem_rd_enb, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_out", instr_out, 0);
    check_eq("rst_pc", instr_pc, 0);
    check_eq("rst_err", stack_err, 0);

    // straight line, JMP, nested BSR/RTS
    load_branch_prog();
    do_reset();
    collect(19, 200);
    for (int i = 0; i < 19; i++) begin
      check_eq($sformatf("seq_pc[%0d]", i), got_pc[i], exp_a[i]);
      check_eq($sformatf("seq_ins[%0d]", i), got_ins[i], ram[exp_a[i]]);
    end
    check_eq("first_valid_cyc", got_cyc[0], 1);
    check_eq("second_cyc", got_cyc[1], 2);
    check_eq("third_cyc", got_cyc[2], 3);
    check_eq("jmp_gap_cyc", got_cyc[3], 6);

    // backpressure: ready low for cycles 10..14
    fill();
    do_reset();
    ncol = 0;
    held = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      instr_ready = !(c >= 10 && c < 15);
      if (c == 10) held = instr_out;
      if (c > 10 && c < 15) begin
        check_eq("stall_valid", instr_valid, 1);
        check_eq("stall_hold", instr_out, held);
      end
      if (instr_valid && instr_ready && ncol < 64) begin
        got_pc[ncol]  = instr_pc;
        got_ins[ncol] = instr_out;
        ncol++;
      end
    end
    instr_ready = 1'b1;
    check_eq("bp_count", ncol, 53);
    for (int i = 0; i < ncol; i++) begin
      check_eq($sformatf("bp_pc[%0d]", i), got_pc[i], i);
      check_eq($sformatf("bp_ins[%0d]", i), got_ins[i], ram[i]);
    end

    // async reset while the BSR at 8 is returning
    load_branch_prog();
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 11'd7) found = 1'b1;
    end
    check_eq("bsr_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", instr_valid, 0);
    check_eq("mid_rst_rd_enb", mem_rd_enb, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    check_eq("mid_rst_pc", instr_pc, 0);
    check_eq("mid_rst_out", instr_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    collect(3, 20);
    check_eq("restart_pc0", got_pc[0], 0);
    check_eq("restart_pc1", got_pc[1], 1);
    check_eq("restart_pc2", got_pc[2], 2);
    check_eq("restart_cyc", got_cyc[0], 1);

    // four nested BSR: stack just full, no error
    fill();
    for (int i = 0; i < 4; i++) ram[i] = enc_bsr(10'd1);
    do_reset();
    repeat (25) @(negedge clk);
    check_eq("bsr4_err", stack_err, 0);

    // five nested BSR: overflow on the fifth
    fill();
    for (int i = 0; i < 5; i++) ram[i] = enc_bsr(10'd1);
    do_reset();
    collect(1, 40);
    check_eq("bsr5_first_pc", got_pc[0], 5);
    check_eq("bsr5_err", stack_err, EXP_ERR);

    // RTS on an empty stack returns to 0
    fill();
    ram[1] = RTS_W;
    do_reset();
    collect(3, 40);
    check_eq("rts_empty_pc0", got_pc[0], 0);
    check_eq("rts_empty_pc1", got_pc[1], 0);
    check_eq("rts_empty_pc2", got_pc[2], 0);
    check_eq("rts_empty_err", stack_err, EXP_ERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
